led_scan_ctrl: RTL and testbench
================================

# led_scan_ctrl

Display refresh controller for the 8x8 light-pen LED matrix. It sequences row-by-row synchronous reads of the 64x4 LED RAM through one-hot row/column read addresses and buffers each row's eight 4-bit intensities. It then drives the matrix row and column lines with 16-level per-pixel PWM. It sits between the LED RAM read port and the matrix pin drivers; write-side arbitration is handled outside this block.

## Interface
Parameters:
- DWELL, 256: clock cycles per PWM slot; must be ≥1.
- PWM_LEVELS, 16: PWM slots per row; fixed to match 4-bit intensity.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  scan enable; level-sensitive.
- ram_addr_row  output  8  one-hot RAM read row address.
- ram_addr_col  output  8  one-hot RAM read column address.
- ram_data  input  4  RAM read data; valid one cycle after the address.
- led_row  output  8  one-hot active-high row select; all zero when blanked.
- led_col  output  8  active-high column drive.
- frame_start  output  1  one-cycle pulse at the start of the row-0 fetch.
- busy  output  1  high whenever not IDLE.

## Operation
- FSM states: IDLE, FETCH, SHOW.
- IDLE:
  - row counter = 0; outputs blanked.
  - Next cycle after en=1 → FETCH of row 0.
- FETCH, 9 cycles, f = 0..8:
  - For f = 0..7: ram_addr_row = onehot(row), ram_addr_col = onehot(f).
  - At f = 1..8, capture ram_data into line buffer lvl[f-1].
  - At f = 8, address holds col 7.
  - led_row = 0 and led_col = 0 for the whole state (ghosting blank).
- SHOW, PWM_LEVELS×DWELL cycles:
  - Slot counter p = 0..15; each slot lasts DWELL cycles.
  - led_row = onehot(row); led_col[c] = (lvl[c] > p).
  - Intensity 0 never lights; intensity 15 lights 15 of 16 slots.
  - After the last cycle of slot 15: row = row+1 (7 wraps to 0) → FETCH.
- frame_start is asserted in FETCH f = 0 when row = 0.
- en=0 in any state:
  - Next cycle is IDLE, outputs blanked, row reset to 0, line buffer retained.
  - A re-enable always restarts at row 0.
- Line buffer is updated only in FETCH. RAM writes landing mid-row take effect at that row's next fetch.

## Timing
- Reset values:
  - ram_addr_row = 8'h01, ram_addr_col = 8'h01.
  - led_row = 0, led_col = 0.
  - frame_start = 0, busy = 0.
  - State IDLE; all counters 0; lvl all 0.
- All outputs are registered; no combinational path from ram_data or en to any output.
- en sampled high in cycle t → FETCH f=0 addresses and busy=1 visible at t+1.
- Row period = 9 + 16·DWELL cycles. Frame period = 8 × row period; DWELL=2 gives 41 and 328.
- First SHOW cycle (led_row nonzero) = 9 cycles after the first FETCH cycle.
- Slot counter width = 4 bits. Dwell counter width = $clog2(DWELL), minimum 1; it wraps at DWELL-1, with no overflow past the terminal count.
- Reset asserted mid-row: immediate asynchronous return to reset values. After reset, the first frame_start follows en by 1 cycle.

## Structure
- Shared header/package led_scan_pkg:
  - NUM_ROWS=8, NUM_COLS=8, PWM_BITS=4.
  - FSM state encodings (2-bit).
  - FETCH_CYCLES=9.
- Natural sub-module: led_pwm_line, holding the 8×4-bit line buffer plus eight `lvl[c] > p` comparators that produce registered led_col.
- One-hot encode via a shared function alongside the decode used in the RAM.

## Test plan
- Reset then idle: rst_n low→high with en=0 for 50 cycles → all outputs at reset values, busy=0, no frame_start.
- Fetch sequence: DWELL=2, en=1 → ram_addr_col steps 01,02,…,80 on consecutive cycles with ram_addr_row=01. frame_start pulses once. led_row=0 for 9 cycles, then 01.
- PWM duty: model RAM row 0 = {0,1,7,15,15,8,3,0} (cols 0..7), DWELL=2 → over 32 SHOW cycles, col0 lit 0 cycles, col1 2, col2 14, col3 30, col7 0.
- Row wrap/frame: en held for 700 cycles at DWELL=2 → led_row sequence 01→02→…→80→01. frame_start spaced exactly 328 cycles apart.
- Mid-row disable: drop en in slot 5 of row 3 → next cycle IDLE, led_row=0, busy=0. Re-enable → fetch resumes at row 0 with frame_start.
- Async reset mid-SHOW: pulse rst_n low for 1 cycle during row 6 → outputs zero immediately. With en=1, row 0 is fetched again.

Source files
------------

// File: rtl/led_scan_pkg.sv
// Shared constants, FSM encoding and one-hot helpers for the LED matrix scan path.
package led_scan_pkg;

   localparam int unsigned NUM_ROWS     = 8;
   localparam int unsigned NUM_COLS     = 8;
   localparam int unsigned PWM_BITS     = 4;
   localparam int unsigned FETCH_CYCLES = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SHOW  = 2'd2
   } state_e;

   function automatic logic [7:0] onehot8(input logic [2:0] idx);
      return 8'd1 << idx;
   endfunction

   // Inverse of onehot8, as used by the RAM-side address decode.
   function automatic logic [2:0] decode8(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (oh[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/led_scan_ctrl_pwm_line.sv
// One-row line buffer of 4-bit intensities and the registered PWM column comparators.
module led_pwm_line
   import led_scan_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cap_en,
   input  logic [2:0]          cap_idx,
   input  logic [PWM_BITS-1:0] cap_data,
   input  logic                show,
   input  logic [PWM_BITS-1:0] slot,
   output logic [NUM_COLS-1:0] led_col
);

   logic [PWM_BITS-1:0] lvl_q [NUM_COLS];
   logic [PWM_BITS-1:0] lvl_d [NUM_COLS];
   logic [NUM_COLS-1:0] led_col_q;
   logic [NUM_COLS-1:0] led_col_d;

   // Compare against the incoming buffer so the last captured column is
   // already correct in the first SHOW cycle.
   always_comb begin
      lvl_d = lvl_q;
      if (cap_en) lvl_d[cap_idx] = cap_data;
      led_col_d = '0;
      if (show) begin
         for (int unsigned c = 0; c < NUM_COLS; c++) begin
            led_col_d[c] = (lvl_d[c] > slot);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_q     <= '{default: '0};
         led_col_q <= '0;
      end else begin
         lvl_q     <= lvl_d;
         led_col_q <= led_col_d;
      end
   end

   assign led_col = led_col_q;

endmodule

// File: rtl/led_scan_ctrl.sv
// Row-by-row fetch of the 64x4 LED RAM and 16-level PWM drive of the 8x8 matrix.
module led_scan_ctrl
   import led_scan_pkg::*;
#(
   parameter int unsigned DWELL      = 256,
   parameter int unsigned PWM_LEVELS = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   output logic [NUM_ROWS-1:0] ram_addr_row,
   output logic [NUM_COLS-1:0] ram_addr_col,
   input  logic [PWM_BITS-1:0] ram_data,
   output logic [NUM_ROWS-1:0] led_row,
   output logic [NUM_COLS-1:0] led_col,
   output logic                frame_start,
   output logic                busy
);

   localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

   state_e              state_q, state_d;
   logic [2:0]          row_q, row_d;
   logic [3:0]          fcnt_q, fcnt_d;
   logic [PWM_BITS-1:0] slot_q, slot_d;
   logic [DW-1:0]       dwell_q, dwell_d;
   logic [NUM_ROWS-1:0] ram_addr_row_q, ram_addr_row_d;
   logic [NUM_COLS-1:0] ram_addr_col_q, ram_addr_col_d;
   logic [NUM_ROWS-1:0] led_row_q, led_row_d;
   logic                frame_start_q, frame_start_d;
   logic                busy_q, busy_d;
   logic                cap_en;
   logic [2:0]          cap_idx;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      fcnt_d  = fcnt_q;
      slot_d  = slot_q;
      dwell_d = dwell_q;
      if (!en) begin
         state_d = ST_IDLE;
         row_d   = '0;
         fcnt_d  = '0;
         slot_d  = '0;
         dwell_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_FETCH;
               fcnt_d  = '0;
            end
            ST_FETCH: begin
               if (fcnt_q == 4'(FETCH_CYCLES - 1)) begin
                  state_d = ST_SHOW;
                  slot_d  = '0;
                  dwell_d = '0;
               end else begin
                  fcnt_d = fcnt_q + 4'd1;
               end
            end
            ST_SHOW: begin
               if (dwell_q == DW'(DWELL - 1)) begin
                  dwell_d = '0;
                  if (slot_q == PWM_BITS'(PWM_LEVELS - 1)) begin
                     state_d = ST_FETCH;
                     fcnt_d  = '0;
                     row_d   = row_q + 3'd1;
                  end else begin
                     slot_d = slot_q + 1'b1;
                  end
               end else begin
                  dwell_d = dwell_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next-state values so each one lines up
   // with the state it belongs to; the RAM address holds its last value in SHOW.
   always_comb begin
      ram_addr_row_d = ram_addr_row_q;
      ram_addr_col_d = ram_addr_col_q;
      if (state_d == ST_IDLE) begin
         ram_addr_row_d = onehot8(3'd0);
         ram_addr_col_d = onehot8(3'd0);
      end else if (state_d == ST_FETCH) begin
         ram_addr_row_d = onehot8(row_d);
         ram_addr_col_d = onehot8(fcnt_d[3] ? 3'd7 : fcnt_d[2:0]);
      end
      led_row_d     = (state_d == ST_SHOW) ? onehot8(row_d) : '0;
      frame_start_d = (state_d == ST_FETCH) && (fcnt_d == 4'd0) && (row_d == 3'd0);
      busy_d        = (state_d != ST_IDLE);
   end

   assign cap_en  = (state_q == ST_FETCH) && (fcnt_q != 4'd0);
   assign cap_idx = 3'(fcnt_q - 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         row_q          <= '0;
         fcnt_q         <= '0;
         slot_q         <= '0;
         dwell_q        <= '0;
         ram_addr_row_q <= 8'h01;
         ram_addr_col_q <= 8'h01;
         led_row_q      <= '0;
         frame_start_q  <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         row_q          <= row_d;
         fcnt_q         <= fcnt_d;
         slot_q         <= slot_d;
         dwell_q        <= dwell_d;
         ram_addr_row_q <= ram_addr_row_d;
         ram_addr_col_q <= ram_addr_col_d;
         led_row_q      <= led_row_d;
         frame_start_q  <= frame_start_d;
         busy_q         <= busy_d;
      end
   end

   led_pwm_line u_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .cap_en   (cap_en),
      .cap_idx  (cap_idx),
      .cap_data (ram_data),
      .show     (state_d == ST_SHOW),
      .slot     (slot_d),
      .led_col  (led_col)
   );

   assign ram_addr_row = ram_addr_row_q;
   assign ram_addr_col = ram_addr_col_q;
   assign led_row      = led_row_q;
   assign frame_start  = frame_start_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl at DWELL=2 with a synchronous 64x4 RAM model.
module tb_led_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] ram_addr_row, ram_addr_col, led_row, led_col;
   logic [3:0] ram_data = 4'd0;
   logic       frame_start, busy;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [3:0] mem [64];

   typedef struct {
      logic [7:0] arow;
      logic [7:0] acol;
      logic [7:0] lrow;
      logic [7:0] lcol;
      logic       fs;
      logic       bsy;
   } vec_t;

   vec_t fetch_tbl [9];

   always #5 clk = ~clk;

   led_scan_ctrl #(.DWELL(2), .PWM_LEVELS(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .ram_addr_row (ram_addr_row),
      .ram_addr_col (ram_addr_col),
      .ram_data     (ram_data),
      .led_row      (led_row),
      .led_col      (led_col),
      .frame_start  (frame_start),
      .busy         (busy)
   );

   function automatic int oh_idx(input logic [7:0] oh);
      int r;
      r = 0;
      for (int i = 0; i < 8; i++) if (oh[i]) r = i;
      return r;
   endfunction

   always @(posedge clk) ram_data <= mem[oh_idx(ram_addr_row) * 8 + oh_idx(ram_addr_col)];

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [33:0] idle_vec();
      return {8'h01, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0};
   endfunction

   function automatic logic [33:0] out_vec();
      return {ram_addr_row, ram_addr_col, led_row, led_col, frame_start, busy};
   endfunction

   initial begin
      int          lit [8];
      int          exp_lit [8];
      int          fs_times [$];
      logic [7:0]  row_seq [$];
      logic [7:0]  col_oh;
      logic [7:0]  row_oh;

      for (int i = 0; i < 64; i++) mem[i] = 4'((i * 5 + 3) % 16);
      mem[0] = 4'd0;  mem[1] = 4'd1;  mem[2] = 4'd7;  mem[3] = 4'd15;
      mem[4] = 4'd15; mem[5] = 4'd8;  mem[6] = 4'd3;  mem[7] = 4'd0;
      exp_lit = '{0, 2, 14, 30, 30, 16, 6, 0};

      for (int k = 0; k < 9; k++) begin
         col_oh = 8'h01;
         fetch_tbl[k].arow = 8'h01;
         fetch_tbl[k].acol = col_oh << ((k > 7) ? 7 : k);
         fetch_tbl[k].lrow = 8'h00;
         fetch_tbl[k].lcol = 8'h00;
         fetch_tbl[k].fs   = (k == 0);
         fetch_tbl[k].bsy  = 1'b1;
      end

      // Reset and idle
      tick();
      check("in_reset", 48'(out_vec()), 48'(idle_vec()));
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         check("idle", 48'(out_vec()), 48'(idle_vec()));
      end

      // Fetch table, PWM duty, row wrap and frame spacing over one run
      for (int c = 0; c < 8; c++) lit[c] = 0;
      en = 1'b1;
      for (int cyc = 0; cyc < 700; cyc++) begin
         tick();
         if (cyc < 9)
            check($sformatf("fetch_f%0d", cyc),
                  48'({ram_addr_row, ram_addr_col, led_row, led_col, frame_start, busy}),
                  48'({fetch_tbl[cyc].arow, fetch_tbl[cyc].acol, fetch_tbl[cyc].lrow,
                       fetch_tbl[cyc].lcol, fetch_tbl[cyc].fs, fetch_tbl[cyc].bsy}));
         if (cyc == 9) begin
            check("first_show_row", 48'(led_row), 48'h01);
            check("first_show_col", 48'(led_col), 48'h7E);
         end
         if (cyc >= 9 && cyc <= 40)
            for (int c = 0; c < 8; c++) if (led_col[c]) lit[c]++;
         if (cyc == 41) begin
            check("row1_fetch_blank", 48'(led_row), 48'h00);
            check("row1_fetch_addr", 48'(ram_addr_row), 48'h02);
         end
         if (frame_start) fs_times.push_back(cyc);
         if (led_row != 8'h00 && (row_seq.size() == 0 || row_seq[$] != led_row))
            row_seq.push_back(led_row);
      end
      for (int c = 0; c < 8; c++) check($sformatf("duty_col%0d", c), 48'(lit[c]), 48'(exp_lit[c]));
      check("fs_count", 48'(fs_times.size()), 48'd3);
      if (fs_times.size() >= 3) begin
         check("fs_first", 48'(fs_times[0]), 48'd0);
         check("fs_gap1", 48'(fs_times[1] - fs_times[0]), 48'd328);
         check("fs_gap2", 48'(fs_times[2] - fs_times[1]), 48'd328);
      end
      check("row_seq_len_min", 48'(row_seq.size() >= 9), 48'd1);
      row_oh = 8'h01;
      for (int i = 0; i < 9; i++) begin
         if (i < row_seq.size())
            check($sformatf("row_seq%0d", i), 48'(row_seq[i]), 48'(row_oh << (i % 8)));
      end

      // Mid-row disable in slot 5 of row 3, then re-enable
      en = 1'b0;
      tick();
      check("disable_restart_idle", 48'(out_vec()), 48'(idle_vec()));
      en = 1'b1;
      for (int i = 0; i < 144; i++) tick();
      check("row3_slot5_row", 48'(led_row), 48'h08);
      en = 1'b0;
      tick();
      check("mid_disable", 48'(out_vec()), 48'(idle_vec()));
      en = 1'b1;
      tick();
      check("reenable", 48'({ram_addr_row, ram_addr_col, led_row, frame_start, busy}),
            48'({8'h01, 8'h01, 8'h00, 1'b1, 1'b1}));
      for (int i = 0; i < 9; i++) tick();
      check("reenable_show_row", 48'(led_row), 48'h01);

      // Async reset pulse during row 6
      for (int i = 0; i < 251; i++) tick();
      check("row6_show", 48'(led_row), 48'h40);
      rst_n = 1'b0;
      #1;
      check("async_reset", 48'(out_vec()), 48'(idle_vec()));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_reset_fetch", 48'({ram_addr_row, ram_addr_col, led_row, frame_start, busy}),
            48'({8'h01, 8'h01, 8'h00, 1'b1, 1'b1}));
      for (int i = 0; i < 9; i++) tick();
      check("post_reset_show", 48'({led_row, led_col}), 48'({8'h01, 8'h7E}));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
